// File: rtl/dmem_lsu.sv
// Load/store responder: one word-wide RAM transaction per request, byte enables, load extension.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fail without a bus cycle.
module dmem_lsu #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              DM_read_en,
    input  logic              DM_write_en,
    input  logic [2:0]        load_store_op,
    input  logic [WIDTH-1:0]  addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              dm_valid,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ERR, S_RESP} state_t;

    localparam logic [3:0] TO_LIM = 4'(TIMEOUT);

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [1:0]        off_reg;
    logic              we_reg;
    logic              err_reg;
    logic [3:0]        cnt_reg;
    logic [WIDTH-1:0]  rdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [3:0]        mem_be_reg;
    logic [WIDTH-1:0]  mem_wdata_reg;

    logic             req_any, legal_op, size_byte, size_half, bad_req, timeout_hit;
    logic [1:0]       off_aligned;
    logic [3:0]       be_dec;
    logic [WIDTH-1:0] wdata_rep, load_ext;
    logic [7:0]       lane_byte [4];
    logic [15:0]      half_sel;

    // Request decode, evaluated only while IDLE
    always_comb begin
        req_any   = DM_write_en | DM_read_en;
        size_byte = (load_store_op == 3'b001) || (load_store_op == 3'b100) || (load_store_op == 3'b110);
        size_half = (load_store_op == 3'b010) || (load_store_op == 3'b101) || (load_store_op == 3'b111);
        if (DM_write_en)
            legal_op = (load_store_op == 3'b001) || (load_store_op == 3'b010) || (load_store_op == 3'b011);
        else
            legal_op = (load_store_op == 3'b000) || load_store_op[2];
        off_aligned = size_byte ? addr[1:0] : (size_half ? {addr[1], 1'b0} : 2'b00);
        be_dec      = size_byte ? (4'b0001 << off_aligned)
                    : (size_half ? (4'b0011 << off_aligned) : 4'b1111);
        if (size_byte)
            wdata_rep = {4{wdata[7:0]}};
        else if (size_half)
            wdata_rep = {2{wdata[15:0]}};
        else
            wdata_rep = wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
        bad_req = !legal_op || (size_half && addr[0]) || (!size_byte && !size_half && (addr[1:0] != 2'b00));
`else
        bad_req = !legal_op;
`endif
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_reg)
            3'b100:  load_ext = {{(WIDTH-8){lane_byte[off_reg][7]}}, lane_byte[off_reg]};
            3'b110:  load_ext = {{(WIDTH-8){1'b0}}, lane_byte[off_reg]};
            3'b101:  load_ext = {{(WIDTH-16){half_sel[15]}}, half_sel};
            3'b111:  load_ext = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    assign timeout_hit = (TO_LIM != 4'd0) && (cnt_reg == TO_LIM - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req_any) state_next = bad_req ? S_ERR : S_REQ;
            S_REQ:   state_next = S_WAIT;
            S_WAIT:  if (mem_ack || timeout_hit) state_next = S_RESP;
            S_ERR:   state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= 3'b000;
            off_reg       <= 2'b00;
            we_reg        <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= 4'd0;
            rdata_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= 4'b0000;
            mem_wdata_reg <= '0;
        end else begin
            cnt_reg <= 4'd0;
            case (state_reg)
                S_IDLE: if (req_any) begin
                    op_reg        <= load_store_op;
                    off_reg       <= off_aligned;
                    we_reg        <= DM_write_en;
                    err_reg       <= bad_req;
                    mem_addr_reg  <= addr[WIDTH-1:2];
                    mem_be_reg    <= be_dec;
                    mem_wdata_reg <= DM_write_en ? wdata_rep : '0;
                end
                S_WAIT: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    // A real ack wins over a timeout landing in the same cycle
                    if (mem_ack) begin
                        err_reg <= 1'b0;
                        if (!we_reg) rdata_reg <= load_ext;
                    end else if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= '0;
                    end
                end
                S_ERR:   rdata_reg <= '0;
                default: ;
            endcase
        end
    end

    assign mem_req   = (state_reg == S_REQ) || (state_reg == S_WAIT);
    assign mem_we    = mem_req && we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;
    assign dm_valid  = (state_reg == S_RESP);
    assign dm_err    = dm_valid && err_reg;
    assign rdata     = rdata_reg;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed plan steps plus random transactions vs. a reference model.
module tb_dmem_lsu;
    localparam int WIDTH   = 32;
    localparam int ADDR_W  = 30;
    localparam int TIMEOUT = 15;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk, rst_n, DM_read_en, DM_write_en, mem_ack;
    logic [2:0]        load_store_op;
    logic [WIDTH-1:0]  addr, wdata, rdata, mem_wdata, mem_rdata;
    logic              dm_valid, dm_err, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    dmem_lsu #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .DM_read_en(DM_read_en), .DM_write_en(DM_write_en),
        .load_store_op(load_store_op), .addr(addr), .wdata(wdata), .rdata(rdata),
        .dm_valid(dm_valid), .dm_err(dm_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size, aligned lane, lane replication and extension by arithmetic
    task automatic model(input bit wr, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mrd,
                         output bit err, output logic [3:0] be,
                         output logic [31:0] mwd, output logic [31:0] rexp);
        int size, off, eff;
        bit legal, mis;
        longint v;
        legal = wr ? (op == 3'd1 || op == 3'd2 || op == 3'd3) : (op == 3'd0 || op >= 3'd4);
        size  = (op == 3'd1 || op == 3'd4 || op == 3'd6) ? 1
              : ((op == 3'd2 || op == 3'd5 || op == 3'd7) ? 2 : 4);
        off = int'(a % 4);
        mis = (off % size) != 0;
        eff = off - (off % size);
        err = !legal || (TRAP && mis);
        be  = 4'(((1 << size) - 1) << eff);
        for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wd[8*(i % size) +: 8];
        v = (longint'(mrd) >> (8*eff)) & ((longint'(1) << (8*size)) - 1);
        if ((op == 3'd4 || op == 3'd5) && v >= (longint'(1) << (8*size - 1)))
            v = v - (longint'(1) << (8*size));
        rexp = err ? 32'h0 : 32'(v);
    endtask

    // ack_dly: WAIT cycle (0 = first) in which mem_ack is given; -1 never acks.
    task automatic run_txn(input string name, input bit wr, input bit rd, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                           input int ack_dly, input bit spurious);
        bit err, done, terr;
        logic [3:0] be_e;
        logic [31:0] mwd_e, r_e;
        int req_cnt, lat_e, reqs_e, c;
        model(wr, op, a, wd, mrd, err, be_e, mwd_e, r_e);
        terr   = !err && ack_dly < 0;
        lat_e  = err ? 2 : (ack_dly < 0 ? 2 + TIMEOUT : 3 + ack_dly);
        reqs_e = err ? 0 : (ack_dly < 0 ? 1 + TIMEOUT : 2 + ack_dly);
        @(negedge clk);
        DM_write_en = wr; DM_read_en = rd; load_store_op = op; addr = a; wdata = wd;
        @(negedge clk);
        DM_write_en = 1'b0; DM_read_en = 1'b0;
        req_cnt = 0; done = 1'b0; c = 1;
        while (!done && c <= 40) begin
            if (c > 1) @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check({name, " mem_addr"}, 32'(mem_addr), a >> 2);
                    check({name, " mem_be"}, 32'(mem_be), 32'(be_e));
                    check({name, " mem_we"}, 32'(mem_we), 32'(wr));
                    if (wr) check({name, " mem_wdata"}, mem_wdata, mwd_e);
                    if (spurious) begin mem_ack = 1'b1; mem_rdata = ~mrd; end
                end
                if (ack_dly >= 0 && req_cnt == 2 + ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = mrd;
                end
            end
            if (dm_valid) begin
                done = 1'b1;
                check({name, " latency"}, 32'(c), 32'(lat_e));
                check({name, " dm_err"}, 32'(dm_err), 32'(err || terr));
                check({name, " req_cycles"}, 32'(req_cnt), 32'(reqs_e));
                if (!wr || err || terr) check({name, " rdata"}, rdata, terr ? 32'h0 : r_e);
            end
            c++;
        end
        mem_ack = 1'b0;
        check({name, " dm_valid_seen"}, 32'(done), 32'd1);
        @(negedge clk);
        check({name, " valid_pulse"}, 32'(dm_valid), 32'd0);
        if (!wr || err || terr) check({name, " rdata_hold"}, rdata, terr ? 32'h0 : r_e);
        $display("txn %s wr=%0d rd=%0d op=%0d addr=0x%08h wdata=0x%08h mrd=0x%08h ack=%0d rdata=0x%08h",
                 name, wr, rd, op, a, wd, mrd, ack_dly, rdata);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; DM_read_en = 1'b0; DM_write_en = 1'b0; load_store_op = 3'd0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        #2;
        check("rst rdata", rdata, 32'h0);
        check("rst dm_valid", 32'(dm_valid), 32'd0);
        check("rst dm_err", 32'(dm_err), 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_txn("sw",     1, 0, 3'b011, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_txn("sb",     1, 0, 3'b001, 32'h0000_0003, 32'h0000_00A5, 32'h0, 0, 0);
        run_txn("lb",     0, 1, 3'b100, 32'h0000_0003, 32'h0, 32'hA500_0000, 0, 0);
        run_txn("lbu",    0, 1, 3'b110, 32'h0000_0003, 32'h0, 32'hA500_0000, 1, 0);
        run_txn("lh",     0, 1, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_1234, 0, 0);
        run_txn("lhu",    0, 1, 3'b111, 32'h0000_0002, 32'h0, 32'h8001_1234, 2, 0);
        run_txn("lw_to",  0, 1, 3'b000, 32'h0000_0040, 32'h0, 32'h1234_5678, -1, 0);
        run_txn("lw_mis", 0, 1, 3'b000, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0, 0);
        run_txn("both_sh",1, 1, 3'b010, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 0, 0);
        run_txn("st_ill", 1, 0, 3'b000, 32'h0000_0020, 32'h1111_2222, 32'h0, 0, 0);
        run_txn("ld_ill", 0, 1, 3'b011, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 0, 0);
        run_txn("ld_sb",  0, 1, 3'b001, 32'h0000_0021, 32'h0, 32'h5555_AAAA, 0, 0);
        run_txn("spur",   0, 1, 3'b000, 32'h0000_0080, 32'h0, 32'h0BAD_CAFE, 1, 1);

        // Reset while waiting for the bus: request drops at once, late ack is ignored
        @(negedge clk);
        DM_read_en = 1'b1; load_store_op = 3'b000; addr = 32'h0000_0100;
        @(negedge clk);
        DM_read_en = 1'b0;
        @(negedge clk);
        check("mid mem_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid mem_req_reset", 32'(mem_req), 32'd0);
        check("mid dm_valid_reset", 32'(dm_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dm_valid || mem_req) seen = 1'b1;
            @(negedge clk);
        end
        check("mid late_ack_ignored", 32'(seen), 32'd0);
        check("mid rdata_cleared", rdata, 32'h0);
        run_txn("sw_after_rst", 1, 0, 3'b011, 32'h0000_0200, 32'h0123_4567, 32'h0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            bit wr, rd;
            int dly;
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            if (!wr && !rd) rd = 1'b1;
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            run_txn($sformatf("rnd%0d", n), wr, rd, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom, dly, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
